// File: rtl/nettlp_cmd_pkg.sv
// Shared NetTLP command-channel types: opcodes, FIFO command word,
// command-master state encoding and the host/wire byte swap.
package nettlp_cmd_pkg;

  localparam int NETTLP_DWADDR_W = 8;

  typedef enum logic [1:0] {
    NETTLP_OPC_REG_NOP = 2'd0,
    NETTLP_OPC_REG_RD  = 2'd1,
    NETTLP_OPC_REG_WR  = 2'd2,
    NETTLP_OPC_REG_RSV = 2'd3
  } NETTLP_OPC_T;

  typedef struct packed {
    NETTLP_OPC_T                opcode;
    logic [NETTLP_DWADDR_W-1:0] dwaddr;
    logic [31:0]                data;
  } FIFO_NETTLP_CMD_T;

  typedef enum logic [2:0] {
    MST_IDLE     = 3'd0,
    MST_PUSH     = 3'd1,
    MST_WAIT_RSP = 3'd2,
    MST_POP      = 3'd3,
    MST_DRAIN    = 3'd4,
    MST_DONE     = 3'd5
  } NETTLP_CMD_MST_STATE_T;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/nettlp_cmd_master_if.sv
// Local request/response handshake plus command and response FIFO ports
// of the NetTLP command master; master = the command master itself.
interface nettlp_cmd_master_if;
  import nettlp_cmd_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [NETTLP_DWADDR_W-1:0] req_dwaddr;
  logic [31:0]                req_wdata;

  logic                       rsp_valid;
  logic [31:0]                rsp_rdata;
  logic                       rsp_timeout;

  logic                       fifo_cmd_o_wr_en;
  logic                       fifo_cmd_o_full;
  FIFO_NETTLP_CMD_T           fifo_cmd_o_din;

  logic                       fifo_cmd_i_rd_en;
  logic                       fifo_cmd_i_empty;
  FIFO_NETTLP_CMD_T           fifo_cmd_i_dout;

  modport master (
    input  req_valid, req_write, req_dwaddr, req_wdata,
    input  fifo_cmd_o_full, fifo_cmd_i_empty, fifo_cmd_i_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output fifo_cmd_o_wr_en, fifo_cmd_o_din, fifo_cmd_i_rd_en
  );

  modport slave (
    output req_valid, req_write, req_dwaddr, req_wdata,
    output fifo_cmd_o_full, fifo_cmd_i_empty, fifo_cmd_i_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  fifo_cmd_o_wr_en, fifo_cmd_o_din, fifo_cmd_i_rd_en
  );

endinterface

// File: rtl/nettlp_cmd_master.sv
// Initiator for adapter-register commands: pushes one request to the command
// FIFO, waits (bounded) for a read response and drains unmatched responses.
//
// state    | meaning
// IDLE     | ready for a request; drains any unsolicited response first
// PUSH     | request latched, waiting for command FIFO space
// WAIT_RSP | read pushed, looking for the matching response
// POP      | bubble after popping a non-matching response
// DRAIN    | bubble after popping a response in IDLE
// DONE     | one-cycle completion pulse
module nettlp_cmd_master
  import nettlp_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STAT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  nettlp_cmd_master_if.master bus,
  output logic [STAT_W-1:0]  stat_stale_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  NETTLP_CMD_MST_STATE_T      state_q, state_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic                       wr_en_q, wr_en_d;
  logic                       rd_en_q, rd_en_d;
  FIFO_NETTLP_CMD_T           din_q, din_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       timeout_q, timeout_d;
  logic [STAT_W-1:0]          stale_q;
  logic                       stale_inc;
  logic                       lat_write_q, lat_write_d;
  logic [NETTLP_DWADDR_W-1:0] lat_dwaddr_q, lat_dwaddr_d;
  logic [31:0]                lat_wdata_q, lat_wdata_d;
  logic                       expired, rsp_match;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    din_d        = din_q;
    rdata_d      = rdata_q;
    timeout_d    = timeout_q;
    stale_inc    = 1'b0;
    lat_write_d  = lat_write_q;
    lat_dwaddr_d = lat_dwaddr_q;
    lat_wdata_d  = lat_wdata_q;
    expired      = (timer_q == TMR_LAST);
    rsp_match    = (bus.fifo_cmd_i_dout.opcode == NETTLP_OPC_REG_RD) &&
                   (bus.fifo_cmd_i_dout.dwaddr == lat_dwaddr_q);

    unique case (state_q)
      MST_IDLE: begin
        if (!bus.fifo_cmd_i_empty) begin
          rd_en_d   = 1'b1;
          stale_inc = 1'b1;
          state_d   = MST_DRAIN;
        end else if (bus.req_valid) begin
          lat_write_d  = bus.req_write;
          lat_dwaddr_d = bus.req_dwaddr;
          lat_wdata_d  = bus.req_wdata;
          timer_d      = '0;
          state_d      = MST_PUSH;
        end
      end
      MST_PUSH: begin
        if (expired) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = MST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (!bus.fifo_cmd_o_full) begin
            wr_en_d      = 1'b1;
            din_d.opcode = lat_write_q ? NETTLP_OPC_REG_WR : NETTLP_OPC_REG_RD;
            din_d.dwaddr = lat_dwaddr_q;
            din_d.data   = bswap32(lat_wdata_q);
            if (lat_write_q) begin
              rdata_d   = '0;
              timeout_d = 1'b0;
              state_d   = MST_DONE;
            end else begin
              state_d = MST_WAIT_RSP;
            end
          end
        end
      end
      // A match in the expiry cycle still completes normally; a mismatch
      // there is left in the FIFO for IDLE to drain.
      MST_WAIT_RSP: begin
        if (!bus.fifo_cmd_i_empty && rsp_match) begin
          rd_en_d   = 1'b1;
          rdata_d   = bswap32(bus.fifo_cmd_i_dout.data);
          timeout_d = 1'b0;
          state_d   = MST_DONE;
        end else if (expired) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = MST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (!bus.fifo_cmd_i_empty) begin
            rd_en_d   = 1'b1;
            stale_inc = 1'b1;
            state_d   = MST_POP;
          end
        end
      end
      MST_POP:   state_d = MST_WAIT_RSP;
      MST_DRAIN: state_d = MST_IDLE;
      MST_DONE:  state_d = MST_IDLE;
      default:   state_d = MST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MST_IDLE;
      timer_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      din_q        <= '0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
      stale_q      <= '0;
      lat_write_q  <= 1'b0;
      lat_dwaddr_q <= '0;
      lat_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      din_q        <= din_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
      lat_write_q  <= lat_write_d;
      lat_dwaddr_q <= lat_dwaddr_d;
      lat_wdata_q  <= lat_wdata_d;
      if (stale_inc && (stale_q != {STAT_W{1'b1}}))
        stale_q <= stale_q + STAT_W'(1);
    end
  end

  // rst gates ready so every output reads 0 while reset is held
  assign bus.req_ready        = !rst && (state_q == MST_IDLE) && bus.fifo_cmd_i_empty;
  assign bus.rsp_valid        = (state_q == MST_DONE);
  assign bus.rsp_rdata        = rdata_q;
  assign bus.rsp_timeout      = timeout_q;
  assign bus.fifo_cmd_o_wr_en = wr_en_q;
  assign bus.fifo_cmd_o_din   = din_q;
  assign bus.fifo_cmd_i_rd_en = rd_en_q;
  assign stat_stale_cnt       = stale_q;

endmodule

// File: tb/tb_nettlp_cmd_master.sv
// Randomized bench for nettlp_cmd_master: FWFT response FIFO model, scripted
// responder and an outcome-level reference (data, timeout, stale count, latency).
module tb_nettlp_cmd_master;
  import nettlp_cmd_pkg::*;

  localparam int TO     = 16;
  localparam int SW     = 4;
  localparam int SAT    = (1 << SW) - 1;

  typedef struct { int due; FIFO_NETTLP_CMD_T w; } inj_t;
  typedef struct { int off; FIFO_NETTLP_CMD_T w; } plan_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] stat_stale_cnt;

  nettlp_cmd_master_if bus();

  nettlp_cmd_master #(.TIMEOUT_CYCLES(TO), .STAT_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .stat_stale_cnt (stat_stale_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
  int wr_cyc = 0, rsp_cyc = 0;
  logic m_rd_en = 1'b0;
  FIFO_NETTLP_CMD_T last_din;
  logic [31:0] rsp_rdata_s;
  logic        rsp_to_s;
  FIFO_NETTLP_CMD_T rspq[$];
  inj_t  inj[$];
  plan_t plan[$];
  int hs, d_wr, d_rd, lat, wlat;
  int exp_stale = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_swap(input logic [31:0] d);
    return ((d & 32'hff) << 24) | (((d >> 8) & 32'hff) << 16) |
           (((d >> 16) & 32'hff) << 8) | ((d >> 24) & 32'hff);
  endfunction

  function automatic FIFO_NETTLP_CMD_T mk(input NETTLP_OPC_T o, input logic [7:0] a,
                                          input logic [31:0] d);
    FIFO_NETTLP_CMD_T w;
    w.opcode = o; w.dwaddr = a; w.data = d;
    return w;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // monitor: samples mid-cycle
  always @(negedge clk) begin
    m_rd_en = bus.fifo_cmd_i_rd_en;
    if (bus.fifo_cmd_o_wr_en) begin wr_cnt++; wr_cyc = cyc; last_din = bus.fifo_cmd_o_din; end
    if (bus.fifo_cmd_i_rd_en) rd_cnt++;
    if (bus.rsp_valid) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_rdata_s = bus.rsp_rdata; rsp_to_s = bus.rsp_timeout;
    end
  end

  // FWFT response FIFO: pop on sampled rd_en, then land scheduled responses
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (m_rd_en && rspq.size() > 0) void'(rspq.pop_front());
    while (inj.size() > 0 && inj[0].due <= cyc) begin
      rspq.push_back(inj[0].w);
      void'(inj.pop_front());
    end
    bus.fifo_cmd_i_empty = (rspq.size() == 0);
    bus.fifo_cmd_i_dout  = (rspq.size() > 0) ? rspq[0] : '0;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic run_req(input bit wr, input logic [7:0] addr, input logic [31:0] wd, input int fl);
    int wr0, rd0, rsp0, n;
    bit planned;
    bus.req_write = wr; bus.req_dwaddr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.req_ready) check_val("handshake_wait", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #2;
    hs = cyc;
    bus.req_valid = 1'b0;
    bus.fifo_cmd_o_full = (fl > 0);
    wr0 = wr_cnt; rd0 = rd_cnt; rsp0 = rsp_cnt; planned = 1'b0; n = 0;
    while (rsp_cnt == rsp0 && n < 200) begin
      @(posedge clk); #2; n++;
      bus.fifo_cmd_o_full = (cyc < hs + fl);
      if (!planned && wr_cnt != wr0) begin
        planned = 1'b1;
        foreach (plan[i]) inj.push_back('{wr_cyc + plan[i].off, plan[i].w});
      end
    end
    bus.fifo_cmd_o_full = 1'b0;
    if (rsp_cnt == rsp0) check_val("rsp_wait", 64'(rsp_cnt), 64'(rsp0 + 1));
    d_wr = wr_cnt - wr0; d_rd = rd_cnt - rd0; lat = rsp_cyc - hs; wlat = wr_cyc - hs;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_dwaddr = '0; bus.req_wdata = '0;
    bus.fifo_cmd_o_full = 0; bus.fifo_cmd_i_empty = 1; bus.fifo_cmd_i_dout = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_wr_en", 64'(bus.fifo_cmd_o_wr_en), 64'd0);
    check_val("rst_rd_en", 64'(bus.fifo_cmd_i_rd_en), 64'd0);
    check_val("rst_stale", 64'(stat_stale_cnt), 64'd0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    check_val("idle_ready", 64'(bus.req_ready), 64'd1);

    // 1: write latency and wire byte order
    plan.delete();
    run_req(1'b1, 8'd2, 32'h11223344, 0);
    check_val("t1_din", 64'(last_din), 64'(mk(NETTLP_OPC_REG_WR, 8'd2, 32'h44332211)));
    check_val("t1_nwr", 64'(d_wr), 64'd1);
    check_val("t1_wlat", 64'(wlat), 64'd1);
    check_val("t1_lat", 64'(lat), 64'd1);
    check_val("t1_timeout", 64'(rsp_to_s), 64'd0);
    @(negedge clk);
    check_val("t1_ready_again", 64'(bus.req_ready), 64'd1);

    // 2: read with response 5 cycles after push
    plan.delete();
    plan.push_back('{5, mk(NETTLP_OPC_REG_RD, 8'd0, 32'h67452301)});
    run_req(1'b0, 8'd0, 32'h0, 0);
    check_val("t2_rdata", 64'(rsp_rdata_s), 64'h01234567);
    check_val("t2_timeout", 64'(rsp_to_s), 64'd0);
    check_val("t2_nrd", 64'(d_rd), 64'd1);
    check_val("t2_din_op", 64'(last_din.opcode), 64'(NETTLP_OPC_REG_RD));

    // 3: read timeout, then late response drained as stale
    plan.delete();
    run_req(1'b0, 8'd9, 32'h0, 0);
    check_val("t3_timeout", 64'(rsp_to_s), 64'd1);
    check_val("t3_rdata", 64'(rsp_rdata_s), 64'd0);
    check_val("t3_lat", 64'(lat), 64'(TO));
    inj.push_back('{cyc + 1, mk(NETTLP_OPC_REG_RD, 8'd9, 32'hdeadbeef)});
    step(5);
    exp_stale = sat(exp_stale + 1);
    check_val("t3_stale", 64'(stat_stale_cnt), 64'(exp_stale));

    // 4: command FIFO full for cycles 1..5
    plan.delete();
    run_req(1'b1, 8'd4, 32'hcafef00d, 5);
    check_val("t4_nwr", 64'(d_wr), 64'd1);
    check_val("t4_wlat", 64'(wlat), 64'd6);
    check_val("t4_lat", 64'(lat), 64'd6);

    // 5: stale response queued ahead of the match
    plan.delete();
    plan.push_back('{2, mk(NETTLP_OPC_REG_RD, 8'd5, 32'h12345678)});
    plan.push_back('{2, mk(NETTLP_OPC_REG_RD, 8'd3, 32'hAABBCCDD)});
    run_req(1'b0, 8'd3, 32'h0, 0);
    exp_stale = sat(exp_stale + 1);
    check_val("t5_rdata", 64'(rsp_rdata_s), 64'hDDCCBBAA);
    check_val("t5_stale", 64'(stat_stale_cnt), 64'(exp_stale));
    check_val("t5_nrd", 64'(d_rd), 64'd2);

    // timeout while still in PUSH: no command may be written
    plan.delete();
    run_req(1'b0, 8'd6, 32'h0, 40);
    check_val("tp_nwr", 64'(d_wr), 64'd0);
    check_val("tp_timeout", 64'(rsp_to_s), 64'd1);
    check_val("tp_lat", 64'(lat), 64'(TO));

    // randomized transactions against the outcome model
    for (int t = 0; t < 40; t++) begin
      bit wr;
      logic [7:0] a;
      logic [31:0] wd, rd_d;
      int fl, mode, oa, ob;
      FIFO_NETTLP_CMD_T bad;
      if ($urandom_range(0, 3) == 0) begin
        inj.push_back('{cyc + 1, mk(NETTLP_OPC_T'(2'($urandom_range(0, 3))), 8'($urandom), $urandom)});
        step(4);
        exp_stale = sat(exp_stale + 1);
      end
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom); wd = $urandom; rd_d = $urandom;
      fl = $urandom_range(0, 3);
      mode = wr ? 0 : $urandom_range(0, 2);
      oa = $urandom_range(2, 4); ob = $urandom_range(1, 3);
      plan.delete();
      if (!wr && mode == 1) begin
        bad = ($urandom_range(0, 1) == 1) ? mk(NETTLP_OPC_REG_WR, a, $urandom)
                                          : mk(NETTLP_OPC_REG_RD, a + 8'd1, $urandom);
        plan.push_back('{oa, bad});
      end
      if (!wr && mode < 2) plan.push_back('{oa + ob, mk(NETTLP_OPC_REG_RD, a, rd_d)});
      run_req(wr, a, wd, fl);
      check_val("rnd_din", 64'(last_din),
                64'(mk(wr ? NETTLP_OPC_REG_WR : NETTLP_OPC_REG_RD, a, ref_swap(wd))));
      check_val("rnd_nwr", 64'(d_wr), 64'd1);
      if (wr) begin
        check_val("rnd_w_timeout", 64'(rsp_to_s), 64'd0);
        check_val("rnd_w_rdata", 64'(rsp_rdata_s), 64'd0);
        check_val("rnd_w_lat", 64'(lat), 64'(1 + fl));
      end else if (mode == 2) begin
        check_val("rnd_to_timeout", 64'(rsp_to_s), 64'd1);
        check_val("rnd_to_rdata", 64'(rsp_rdata_s), 64'd0);
        check_val("rnd_to_lat", 64'(lat), 64'(TO));
        inj.push_back('{cyc + 1, mk(NETTLP_OPC_REG_RD, a, rd_d)});
        step(5);
        exp_stale = sat(exp_stale + 1);
      end else begin
        check_val("rnd_r_timeout", 64'(rsp_to_s), 64'd0);
        check_val("rnd_r_rdata", 64'(rsp_rdata_s), 64'(ref_swap(rd_d)));
        check_val("rnd_r_nrd", 64'(d_rd), 64'(mode + 1));
        exp_stale = sat(exp_stale + mode);
      end
      check_val("rnd_stale", 64'(stat_stale_cnt), 64'(exp_stale));
    end

    // 6: asynchronous reset while waiting for a read response
    bus.req_write = 1'b0; bus.req_dwaddr = 8'd7; bus.req_wdata = 32'h5a5a5a5a; bus.req_valid = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 50 && !bus.req_ready; n++) @(negedge clk);
    @(posedge clk); #2; bus.req_valid = 1'b0;
    step(6);
    #1; rst = 1'b1;
    #1;
    check_val("t6_ready", 64'(bus.req_ready), 64'd0);
    check_val("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("t6_wr_en", 64'(bus.fifo_cmd_o_wr_en), 64'd0);
    check_val("t6_rd_en", 64'(bus.fifo_cmd_i_rd_en), 64'd0);
    check_val("t6_din", 64'(bus.fifo_cmd_o_din), 64'd0);
    check_val("t6_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_val("t6_timeout", 64'(bus.rsp_timeout), 64'd0);
    check_val("t6_stale", 64'(stat_stale_cnt), 64'd0);
    exp_stale = 0;
    @(posedge clk); #2; rst = 1'b0;
    hs = rsp_cnt;
    inj.push_back('{cyc + 1, mk(NETTLP_OPC_REG_RD, 8'd7, 32'h11111111)});
    step(5);
    exp_stale = sat(exp_stale + 1);
    check_val("t6_post_stale", 64'(stat_stale_cnt), 64'(exp_stale));
    check_val("t6_no_rsp", 64'(rsp_cnt), 64'(hs));
    @(negedge clk);
    check_val("t6_idle_ready", 64'(bus.req_ready), 64'd1);

    // stale counter saturation
    for (int i = 0; i < SAT - 1; i++)
      inj.push_back('{cyc + 1, mk(NETTLP_OPC_REG_WR, 8'(i), $urandom)});
    step(2 * SAT + 6);
    exp_stale = sat(exp_stale + SAT - 1);
    check_val("sat_reach", 64'(stat_stale_cnt), 64'(exp_stale));
    for (int i = 0; i < 3; i++)
      inj.push_back('{cyc + 1, mk(NETTLP_OPC_REG_RD, 8'(i), $urandom)});
    step(12);
    exp_stale = sat(exp_stale + 3);
    check_val("sat_hold", 64'(stat_stale_cnt), 64'(exp_stale));
    check_val("sat_drained", 64'(rspq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
